// File: rtl/n_bit_updn_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : n_bit_updn_mod_counter
// Description : Up/down modulo-MOD counter with parallel load, count enable,
//               wrap or one-shot mode and a registered terminal-count flag.
// Revision    : 1.0  initial release
// ============================================================================
module n_bit_updn_mod_counter #(
    parameter int N        = 3,
    parameter int MOD      = 8,
    parameter int ONE_SHOT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count_out,
    output logic         done
);

    localparam logic [N-1:0] c_max  = N'(MOD - 1);
    localparam logic [N-1:0] c_zero = '0;
    localparam logic [N-1:0] c_one  = N'(1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         done_q, done_d;

    logic [N-1:0] w_term;
    logic [N-1:0] w_step;
    logic         w_at_term;

    // Terminal value follows the direction sampled on this edge; the step
    // wraps modulo MOD rather than modulo 2**N.
    always_comb begin
        w_term    = up_dn ? c_max : c_zero;
        w_at_term = (count_q == w_term);
        if (up_dn) begin
            w_step = w_at_term ? c_zero : (count_q + c_one);
        end else begin
            w_step = w_at_term ? c_max : (count_q - c_one);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        if (load) begin
            count_d = (load_val > c_max) ? c_max : load_val;
            done_d  = 1'b0;
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            if (!en) begin
                done_d = 1'b0;
            end else if (ONE_SHOT != 0) begin
                if (w_at_term) begin
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    count_d = w_step;
                    done_d  = (w_step == w_term);
                    state_d = (w_step == w_term) ? S_HALT : S_RUN;
                end
            end else begin
                count_d = w_step;
                done_d  = w_at_term;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            count_q <= c_zero;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count_out = count_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_n_bit_updn_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_n_bit_updn_mod_counter
// Description : Three counter configurations share one directed stimulus and
//               are checked every cycle against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_n_bit_updn_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;

    logic [2:0] cnt0, cnt1, cnt2;
    logic       done0, done1, done2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    n_bit_updn_mod_counter #(.N(3), .MOD(8), .ONE_SHOT(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count_out(cnt0), .done(done0));
    n_bit_updn_mod_counter #(.N(3), .MOD(5), .ONE_SHOT(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count_out(cnt1), .done(done1));
    n_bit_updn_mod_counter #(.N(3), .MOD(8), .ONE_SHOT(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count_out(cnt2), .done(done2));

    int m_mod[3]  = '{8, 5, 8};
    bit m_os[3]   = '{1'b0, 1'b0, 1'b1};
    int m_cnt[3]  = '{0, 0, 0};
    bit m_done[3] = '{1'b0, 1'b0, 1'b0};
    bit m_halt[3] = '{1'b0, 1'b0, 1'b0};
    bit m_valid   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: each configuration described by its rules, in plain integers.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int term;
            term = up_dn ? m_mod[i] - 1 : 0;
            if (rst) begin
                m_cnt[i] = 0; m_done[i] = 1'b0; m_halt[i] = 1'b0;
            end else if (load) begin
                m_cnt[i]  = (int'(load_val) > m_mod[i] - 1) ? m_mod[i] - 1 : int'(load_val);
                m_done[i] = 1'b0; m_halt[i] = 1'b0;
            end else if (m_halt[i]) begin
                // frozen until load or reset
            end else if (!en) begin
                m_done[i] = 1'b0;
            end else if (m_os[i]) begin
                if (m_cnt[i] == term) begin
                    m_done[i] = 1'b1; m_halt[i] = 1'b1;
                end else begin
                    m_cnt[i]  = (m_cnt[i] + (up_dn ? 1 : m_mod[i] - 1)) % m_mod[i];
                    m_done[i] = (m_cnt[i] == term);
                    m_halt[i] = m_done[i];
                end
            end else begin
                m_done[i] = (m_cnt[i] == term);
                m_cnt[i]  = (m_cnt[i] + (up_dn ? 1 : m_mod[i] - 1)) % m_mod[i];
            end
        end
        if (rst) m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("u0.count", int'(cnt0), m_cnt[0]);
            chk("u0.done",  int'(done0), int'(m_done[0]));
            chk("u1.count", int'(cnt1), m_cnt[1]);
            chk("u1.done",  int'(done1), int'(m_done[1]));
            chk("u2.count", int'(cnt2), m_cnt[2]);
            chk("u2.done",  int'(done2), int'(m_done[2]));
        end
    end

    // Called at a falling edge; returns at the next one with results visible.
    task automatic drive(input bit r, input bit l, input bit e, input bit u, input int lv);
        rst = r; load = l; en = e; up_dn = u; load_val = 3'(lv);
        @(negedge clk);
    endtask

    initial begin
        int exp_up[10];
        int exp_dn[9];
        exp_up = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
        exp_dn = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

        drive(1, 0, 0, 1, 0);
        chk("reset.count", int'(cnt0), 0);
        chk("reset.done", int'(done0), 0);

        // Free-running up count with a single wrap pulse
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 1, 0);
            chk("t1.count", int'(cnt0), exp_up[i]);
            chk("t1.done", int'(done0), (exp_up[i] == 0) ? 1 : 0);
        end

        // Down count from reset wraps immediately to MOD-1
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, 0, 0);
            chk("t2.count", int'(cnt0), exp_dn[i]);
            chk("t2.done", int'(done0), (i == 0 || i == 8) ? 1 : 0);
        end

        // Load above MOD-1 saturates in the MOD=5 instance
        drive(0, 1, 0, 1, 6);
        chk("t3.load_sat", int'(cnt1), 4);
        chk("t3.load_nosat", int'(cnt0), 6);
        drive(0, 0, 1, 1, 0);
        chk("t3.wrap", int'(cnt1), 0);
        chk("t3.wrap_done", int'(done1), 1);
        drive(0, 0, 1, 1, 0);
        chk("t3.after", int'(cnt1), 1);
        chk("t3.after_done", int'(done1), 0);

        // One-shot: stop at zero and hold until reload
        drive(0, 1, 0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0);
            chk("t4.count", int'(cnt2), 2 - i);
            chk("t4.done", int'(done2), (i == 2) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0);
            chk("t4.hold_count", int'(cnt2), 0);
            chk("t4.hold_done", int'(done2), 1);
        end
        drive(0, 0, 0, 0, 0);
        chk("t4.hold_en0", int'(done2), 1);
        drive(0, 1, 0, 0, 2);
        chk("t4.reload", int'(cnt2), 2);
        chk("t4.reload_done", int'(done2), 0);
        drive(0, 0, 1, 0, 0);
        chk("t4.resume", int'(cnt2), 1);

        // Load beats enable; reset beats load
        drive(0, 1, 1, 1, 5);
        chk("t5.load_pri", int'(cnt0), 5);
        drive(0, 0, 1, 1, 0);
        chk("t5.to6", int'(cnt0), 6);
        drive(1, 1, 1, 1, 3);
        chk("t5.rst_pri", int'(cnt0), 0);
        chk("t5.rst_done", int'(done0), 0);

        // Enable toggled around the 7->0 wrap
        drive(0, 1, 0, 1, 7);
        drive(0, 0, 0, 1, 0);
        chk("t6.hold7", int'(cnt0), 7);
        drive(0, 0, 1, 1, 0);
        chk("t6.wrap", int'(cnt0), 0);
        chk("t6.pulse", int'(done0), 1);
        drive(0, 0, 0, 1, 0);
        chk("t6.hold0", int'(cnt0), 0);
        chk("t6.pulse_end", int'(done0), 0);
        drive(0, 0, 1, 1, 0);
        chk("t6.step1", int'(cnt0), 1);
        chk("t6.no_pulse", int'(done0), 0);

        // Direction change mid-count
        drive(0, 0, 1, 1, 0);
        chk("t7.up2", int'(cnt0), 2);
        drive(0, 0, 1, 0, 0);
        chk("t7.dn1", int'(cnt0), 1);
        drive(0, 0, 1, 0, 0);
        chk("t7.dn0", int'(cnt0), 0);
        chk("t7.dn0_done", int'(done0), 0);
        drive(0, 0, 1, 0, 0);
        chk("t7.wrap7", int'(cnt0), 7);
        chk("t7.wrap7_done", int'(done0), 1);

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
